timer_param_ctrl: RTL and testbench
===================================

TIMER_PARAM_CTRL -- requirements
Module: timer_param_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 27000000, meaning clk cycles per second (benches use 4).
REQ-002 The block SHALL have parameters T_ARM, T_DRIVER, T_PASSENGER, T_ALARM, defaults 6, 8, 15, 10, meaning reset values in seconds of interval slots 00, 01, 10, 11.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port reprogram  input  1  write prog_val into slot prog_sel this cycle.
REQ-006 The block SHALL have port prog_sel  input  2  slot index for reprogram.
REQ-007 The block SHALL have port prog_val  input  4  new slot value in seconds (0-15).
REQ-008 The block SHALL have port interval  input  2  slot selected by start_timer.
REQ-009 The block SHALL have port start_timer  input  1  load and start countdown from slot interval.
REQ-010 The block SHALL have port expired  output  1  registered one-cycle pulse at countdown end.
REQ-011 The block SHALL have port busy  output  1  countdown running.
REQ-012 The block SHALL have port time_left  output  4  remaining whole seconds.
REQ-013 The block SHALL have port one_hz  output  1  one-cycle tick, every CLK_HZ cycles.

Function
REQ-014 The block SHALL hold four 4-bit slot registers, slot width fixed at 4 bits, no saturation logic needed.
REQ-015 The divider SHALL count 0..CLK_HZ-1 and wrap. one_hz SHALL be combinational: high while count == CLK_HZ-1.
REQ-016 The block SHALL implement states IDLE (busy=0) and RUN (busy=1).
REQ-017 On an edge with reprogram=1, slot[prog_sel] SHALL take prog_val, the block SHALL go to IDLE, time_left SHALL be 0, and expired SHALL stay 0.
REQ-018 reprogram SHALL take priority over start_timer on the same edge; the start is dropped.
REQ-019 On an edge with start_timer=1 and reprogram=0, the block SHALL load time_left from slot[interval] (pre-edge contents) and clear the divider count to 0, in either state (a start while in RUN restarts).
REQ-020 On that start edge, a loaded value of 0 SHALL set expired for the next cycle and leave the block in IDLE; any nonzero value SHALL enter RUN.
REQ-021 In RUN, on an edge with one_hz=1 and time_left > 1, time_left SHALL decrement by 1.
REQ-022 In RUN, on an edge with one_hz=1 and time_left == 1, time_left SHALL become 0, the block SHALL go to IDLE, and expired SHALL be 1 for exactly one cycle.
REQ-023 Latency: for a loaded value N, expired SHALL be high in the cycle following edge N*CLK_HZ, counting the start edge as edge 0.
REQ-024 expired SHALL be 0 in every other cycle; the divider SHALL run freely in IDLE; one_hz SHALL have no effect in IDLE.

Reset
REQ-025 While reset=1 (sampled at the edge), the block SHALL go to IDLE and clear time_left, expired and the divider count to 0, overriding reprogram and start_timer.
REQ-026 While reset=1, slots SHALL take T_ARM, T_DRIVER, T_PASSENGER, T_ALARM.
REQ-027 Reset mid-countdown SHALL abort it; no expired pulse SHALL follow.

Verification (CLK_HZ=4, default slots)
REQ-028 Reset, start_timer with interval=01 at edge 0 -> busy=1, time_left=8; time_left=7 after edge 4; expired high one cycle after edge 32; busy=0 after edge 32.
REQ-029 reprogram sel=10 val=3, then start interval=10 -> expired one cycle after edge 12; with interval=11, time_left loads 10 (other slots unchanged).
REQ-030 reprogram sel=00 val=0, then start interval=00 -> expired high the cycle after the start edge; busy stays 0.
REQ-031 start interval=11 at edge 0, start interval=01 at edge 6 -> time_left=8 after edge 6; expired one cycle after edge 38 only.
REQ-032 reprogram and start_timer on the same edge during RUN -> busy=0, time_left=0, no expired; slot updated.
REQ-033 reset at edge 10 of a countdown with interval=10 -> busy=0, time_left=0, no expired pulse afterward; slot values back to defaults.

Source files
------------

// File: rtl/timer_param_ctrl.sv
// Programmable-interval countdown timer: four 4-bit second slots, a free-running
// CLK_HZ divider producing one_hz, and an IDLE/RUN controller with an expired pulse.
module timer_param_ctrl #(
    parameter int CLK_HZ      = 27000000,
    parameter int T_ARM       = 6,
    parameter int T_DRIVER    = 8,
    parameter int T_PASSENGER = 15,
    parameter int T_ALARM     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reprogram,
    input  logic [1:0] prog_sel,
    input  logic [3:0] prog_val,
    input  logic [1:0] interval,
    input  logic       start_timer,
    output logic       expired,
    output logic       busy,
    output logic [3:0] time_left,
    output logic       one_hz
);

    localparam int              CNT_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] div_cnt;
    logic [3:0]       slot [4];
    logic [3:0]       load_val;
    logic             start_ok;

    // A start only counts when it is not overridden by a same-edge reprogram.
    assign start_ok = start_timer && !reprogram;
    assign load_val = slot[interval];
    assign one_hz   = (div_cnt == CNT_LAST);
    assign busy     = (state == RUN);

    // Divider: free-running, realigned on every accepted start so the first
    // decrement lands exactly CLK_HZ edges after the start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (start_ok || one_hz) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot[0] <= 4'(T_ARM);
            slot[1] <= 4'(T_DRIVER);
            slot[2] <= 4'(T_PASSENGER);
            slot[3] <= 4'(T_ALARM);
        end else if (reprogram) begin
            slot[prog_sel] <= prog_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            time_left <= 4'd0;
            expired   <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (reprogram) begin
                state     <= IDLE;
                time_left <= 4'd0;
            end else if (start_timer) begin
                // Load uses the pre-edge slot contents; a zero interval expires at once.
                time_left <= load_val;
                if (load_val == 4'd0) begin
                    state   <= IDLE;
                    expired <= 1'b1;
                end else begin
                    state <= RUN;
                end
            end else if (state == RUN && one_hz) begin
                if (time_left > 4'd1) begin
                    time_left <= time_left - 4'd1;
                end else begin
                    time_left <= 4'd0;
                    state     <= IDLE;
                    expired   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_param_ctrl.sv
// Directed bench for timer_param_ctrl at CLK_HZ=4 with default slot values.
module tb_timer_param_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       reprogram = 1'b0;
    logic [1:0] prog_sel = 2'd0;
    logic [3:0] prog_val = 4'd0;
    logic [1:0] interval = 2'd0;
    logic       start_timer = 1'b0;
    logic       expired;
    logic       busy;
    logic [3:0] time_left;
    logic       one_hz;

    int n_checks = 0;
    int n_fail   = 0;

    timer_param_ctrl #(
        .CLK_HZ(4), .T_ARM(6), .T_DRIVER(8), .T_PASSENGER(15), .T_ALARM(10)
    ) dut (
        .clk(clk), .reset(reset), .reprogram(reprogram), .prog_sel(prog_sel),
        .prog_val(prog_val), .interval(interval), .start_timer(start_timer),
        .expired(expired), .busy(busy), .time_left(time_left), .one_hz(one_hz)
    );

    always #5 clk = ~clk;

    // Advance n rising edges; outputs are observed 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; reprogram = 1'b0; start_timer = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] sel);
        interval = sel; start_timer = 1'b1;
        step(1);
        start_timer = 1'b0;
    endtask

    task automatic do_prog(input logic [1:0] sel, input logic [3:0] val);
        prog_sel = sel; prog_val = val; reprogram = 1'b1;
        step(1);
        reprogram = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_checks++; if (time_left !== 4'd0) begin n_fail++; $display("FAIL rst_time_left: got %0d want 0", time_left); end
        n_checks++; if (expired !== 1'b0) begin n_fail++; $display("FAIL rst_expired: got %0b want 0", expired); end
        n_checks++; if (one_hz !== 1'b0) begin n_fail++; $display("FAIL rst_one_hz: got %0b want 0", one_hz); end
        step(3);
        n_checks++; if (one_hz !== 1'b1) begin n_fail++; $display("FAIL idle_one_hz_tick: got %0b want 1", one_hz); end
        step(1);
        n_checks++; if (one_hz !== 1'b0) begin n_fail++; $display("FAIL idle_one_hz_wrap: got %0b want 0", one_hz); end
        n_checks++; if (busy !== 1'b0 || time_left !== 4'd0 || expired !== 1'b0) begin
            n_fail++; $display("FAIL idle_tick_no_effect: got busy=%0b tl=%0d exp=%0b want 0/0/0", busy, time_left, expired);
        end
    endtask

    task automatic test_basic();
        do_reset();
        do_start(2'd1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b want 1", busy); end
        n_checks++; if (time_left !== 4'd8) begin n_fail++; $display("FAIL basic_load: got %0d want 8", time_left); end
        step(3);
        n_checks++; if (time_left !== 4'd8) begin n_fail++; $display("FAIL basic_edge3: got %0d want 8", time_left); end
        step(1);
        n_checks++; if (time_left !== 4'd7) begin n_fail++; $display("FAIL basic_edge4: got %0d want 7", time_left); end
        step(27);
        n_checks++; if (time_left !== 4'd1 || busy !== 1'b1 || expired !== 1'b0) begin
            n_fail++; $display("FAIL basic_edge31: got tl=%0d busy=%0b exp=%0b want 1/1/0", time_left, busy, expired);
        end
        step(1);
        n_checks++; if (expired !== 1'b1) begin n_fail++; $display("FAIL basic_expired: got %0b want 1", expired); end
        n_checks++; if (busy !== 1'b0 || time_left !== 4'd0) begin
            n_fail++; $display("FAIL basic_done: got busy=%0b tl=%0d want 0/0", busy, time_left);
        end
        step(1);
        n_checks++; if (expired !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %0b want 0", expired); end
    endtask

    task automatic test_reprogram();
        do_reset();
        do_prog(2'd2, 4'd3);
        n_checks++; if (busy !== 1'b0 || time_left !== 4'd0 || expired !== 1'b0) begin
            n_fail++; $display("FAIL prog_idle: got busy=%0b tl=%0d exp=%0b want 0/0/0", busy, time_left, expired);
        end
        do_start(2'd2);
        n_checks++; if (time_left !== 4'd3) begin n_fail++; $display("FAIL prog_load: got %0d want 3", time_left); end
        step(11);
        n_checks++; if (expired !== 1'b0 || time_left !== 4'd1) begin
            n_fail++; $display("FAIL prog_edge11: got exp=%0b tl=%0d want 0/1", expired, time_left);
        end
        step(1);
        n_checks++; if (expired !== 1'b1) begin n_fail++; $display("FAIL prog_expired: got %0b want 1", expired); end
        do_start(2'd3);
        n_checks++; if (time_left !== 4'd10) begin n_fail++; $display("FAIL prog_slot3: got %0d want 10", time_left); end
        do_start(2'd0);
        n_checks++; if (time_left !== 4'd6) begin n_fail++; $display("FAIL prog_slot0: got %0d want 6", time_left); end
        do_start(2'd1);
        n_checks++; if (time_left !== 4'd8) begin n_fail++; $display("FAIL prog_slot1: got %0d want 8", time_left); end
    endtask

    task automatic test_zero();
        do_reset();
        do_prog(2'd0, 4'd0);
        do_start(2'd0);
        n_checks++; if (expired !== 1'b1) begin n_fail++; $display("FAIL zero_expired: got %0b want 1", expired); end
        n_checks++; if (busy !== 1'b0 || time_left !== 4'd0) begin
            n_fail++; $display("FAIL zero_idle: got busy=%0b tl=%0d want 0/0", busy, time_left);
        end
        step(1);
        n_checks++; if (expired !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_after: got exp=%0b busy=%0b want 0/0", expired, busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_start(2'd3);
        step(5);
        n_checks++; if (time_left !== 4'd9) begin n_fail++; $display("FAIL b2b_edge5: got %0d want 9", time_left); end
        do_start(2'd1);
        n_checks++; if (time_left !== 4'd8 || busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_restart: got tl=%0d busy=%0b want 8/1", time_left, busy);
        end
        // Edges 7..42: the only pulse allowed is after edge 38.
        for (int e = 7; e <= 42; e++) begin
            step(1);
            n_checks++;
            if (expired !== (e == 38)) begin
                n_fail++; $display("FAIL b2b_expired_edge%0d: got %0b want %0b", e, expired, (e == 38));
            end
        end
    endtask

    task automatic test_priority();
        do_reset();
        do_start(2'd1);
        step(3);
        prog_sel = 2'd1; prog_val = 4'd5; reprogram = 1'b1;
        interval = 2'd2; start_timer = 1'b1;
        step(1);
        reprogram = 1'b0; start_timer = 1'b0;
        n_checks++; if (busy !== 1'b0 || time_left !== 4'd0 || expired !== 1'b0) begin
            n_fail++; $display("FAIL prio_state: got busy=%0b tl=%0d exp=%0b want 0/0/0", busy, time_left, expired);
        end
        for (int e = 0; e < 12; e++) begin
            step(1);
            n_checks++;
            if (expired !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL prio_quiet_%0d: got exp=%0b busy=%0b want 0/0", e, expired, busy);
            end
        end
        do_start(2'd1);
        n_checks++; if (time_left !== 4'd5) begin n_fail++; $display("FAIL prio_slot_updated: got %0d want 5", time_left); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_prog(2'd2, 4'd3);
        do_start(2'd2);
        step(9);
        n_checks++; if (busy !== 1'b1 || time_left !== 4'd1) begin
            n_fail++; $display("FAIL rmid_edge9: got busy=%0b tl=%0d want 1/1", busy, time_left);
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0 || time_left !== 4'd0 || expired !== 1'b0) begin
            n_fail++; $display("FAIL rmid_abort: got busy=%0b tl=%0d exp=%0b want 0/0/0", busy, time_left, expired);
        end
        for (int e = 0; e < 8; e++) begin
            step(1);
            n_checks++;
            if (expired !== 1'b0) begin n_fail++; $display("FAIL rmid_no_pulse_%0d: got %0b want 0", e, expired); end
        end
        do_start(2'd2);
        n_checks++; if (time_left !== 4'd15) begin n_fail++; $display("FAIL rmid_slot_default: got %0d want 15", time_left); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reprogram();
        test_zero();
        test_back_to_back();
        test_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
